// File: rtl/disk_dma_ctrl_pkg.sv
// Shared definitions for the disk DMA engine and the CPU I/O unit that drives it.
// Provides the controller state encoding, transfer-direction constants and the
// default disk/memory sizes used for range checking.
package disk_dma_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } dma_state_e;

  localparam logic DIR_LOAD  = 1'b0;  // disk -> memory
  localparam logic DIR_STORE = 1'b1;  // memory -> disk

  localparam int unsigned DEFAULT_DISK_SIZE = 1024;
  localparam int unsigned DEFAULT_MEM_SIZE  = 1024;

endpackage

// File: rtl/disk_dma_ctrl.sv
// Word-copy engine between the disk and main memory.
// One word moves every two cycles: an RD cycle presents the source address, and
// the following WR cycle writes the captured word to the destination.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               one-cycle request, only honoured in IDLE
//   dir_i                 DIR_LOAD (disk->mem) or DIR_STORE (mem->disk)
//   disk_base_i, mem_base_i, length_i   transfer descriptor, latched at start
//   disk_*_o / disk_rdata_i   disk write enable, address, write data, read data
//   mem_*_o  / mem_rdata_i    memory write enable, address, write data, read data
//   busy_o                high while a request is in flight, including DONE
//   done_o, error_o       completion pulse; error marks a rejected range
//   count_o               words written in the current or last transfer
module disk_dma_ctrl
  import disk_dma_ctrl_pkg::*;
#(
  parameter int unsigned DISK_SIZE = DEFAULT_DISK_SIZE,
  parameter int unsigned MEM_SIZE  = DEFAULT_MEM_SIZE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [31:0] disk_base_i,
  input  logic [31:0] mem_base_i,
  input  logic [31:0] length_i,
  output logic        disk_we_o,
  output logic [31:0] disk_addr_o,
  output logic [31:0] disk_wdata_o,
  input  logic [31:0] disk_rdata_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] count_o
);

  dma_state_e  state_q, state_d;
  logic        dir_q, dir_d;
  logic [31:0] disk_base_q, disk_base_d;
  logic [31:0] mem_base_q, mem_base_d;
  logic [31:0] len_q, len_d;
  logic [31:0] count_q, count_d;
  logic        error_q, error_d;
  logic        disk_we_q, disk_we_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] disk_addr_q, disk_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  // The write-data registers double as the one-word transfer buffer.
  logic [31:0] disk_wdata_q, disk_wdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [32:0] disk_end, mem_end;
  logic        range_err;
  logic [31:0] next_cnt;

  // 33-bit sums so a base+length that wraps 32 bits is still out of range.
  always_comb begin
    disk_end  = {1'b0, disk_base_i} + {1'b0, length_i};
    mem_end   = {1'b0, mem_base_i} + {1'b0, length_i};
    range_err = (disk_end > 33'(DISK_SIZE)) || (mem_end > 33'(MEM_SIZE));
    next_cnt  = count_q + 32'd1;
  end

  // All outputs are registered: the next-state logic computes what the coming
  // cycle presents, so reset clears every output asynchronously.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    disk_base_d  = disk_base_q;
    mem_base_d   = mem_base_q;
    len_d        = len_q;
    count_d      = count_q;
    error_d      = error_q;
    disk_we_d    = 1'b0;
    mem_we_d     = 1'b0;
    disk_addr_d  = disk_addr_q;
    mem_addr_d   = mem_addr_q;
    disk_wdata_d = disk_wdata_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          dir_d       = dir_i;
          disk_base_d = disk_base_i;
          mem_base_d  = mem_base_i;
          len_d       = length_i;
          count_d     = '0;
          error_d     = 1'b0;
          if (range_err) begin
            state_d = StDone;
            error_d = 1'b1;
          end else if (length_i == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRd;
            if (dir_i == DIR_LOAD) disk_addr_d = disk_base_i;
            else                   mem_addr_d  = mem_base_i;
          end
        end
      end
      StRd: begin
        state_d = StWr;
        if (dir_q == DIR_LOAD) begin
          mem_addr_d  = mem_base_q + count_q;
          mem_wdata_d = disk_rdata_i;
          mem_we_d    = 1'b1;
        end else begin
          disk_addr_d  = disk_base_q + count_q;
          disk_wdata_d = mem_rdata_i;
          disk_we_d    = 1'b1;
        end
      end
      StWr: begin
        count_d = next_cnt;
        if (next_cnt == len_q) begin
          state_d = StDone;
        end else begin
          state_d = StRd;
          if (dir_q == DIR_LOAD) disk_addr_d = disk_base_q + next_cnt;
          else                   mem_addr_d  = mem_base_q + next_cnt;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      dir_q        <= DIR_LOAD;
      disk_base_q  <= '0;
      mem_base_q   <= '0;
      len_q        <= '0;
      count_q      <= '0;
      error_q      <= 1'b0;
      disk_we_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      disk_addr_q  <= '0;
      mem_addr_q   <= '0;
      disk_wdata_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      disk_base_q  <= disk_base_d;
      mem_base_q   <= mem_base_d;
      len_q        <= len_d;
      count_q      <= count_d;
      error_q      <= error_d;
      disk_we_q    <= disk_we_d;
      mem_we_q     <= mem_we_d;
      disk_addr_q  <= disk_addr_d;
      mem_addr_q   <= mem_addr_d;
      disk_wdata_q <= disk_wdata_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign disk_we_o    = disk_we_q;
  assign mem_we_o     = mem_we_q;
  assign disk_addr_o  = disk_addr_q;
  assign mem_addr_o   = mem_addr_q;
  assign disk_wdata_o = disk_wdata_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign error_o      = (state_q == StDone) && error_q;
  assign count_o      = count_q;

endmodule
